tlb_front_end: RTL and testbench
================================

Name: tlb_front_end

Overview:
- Small fully-associative TLB placed directly upstream of PAGE_TABLE_32B.
- Accepts 9-bit virtual addresses (VPN = addr[8:5], offset = addr[4:0]) and answers hits in one cycle.
- On a miss, issues a single lookup to the page table (LOOKUP_RQST/LOOKUP_ADDR), waits for LOOKUP_COMPLETE/LOOKUP_RETURN, fills an entry, then responds.
- Exports hit/miss counters for the speculation experiments.

Parameters:
- NUM_ENTRIES, 4, TLB entries; power of two, 2..16.
- VPN_W, 4, virtual page number width.
- OFF_W, 5, page offset width.
- PPN_W, 8, physical page number width; equals the page-table return width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  translation request.
- req_addr  in  VPN_W+OFF_W  virtual address.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at a posedge.
- flush  in  1  invalidate all entries.
- resp_valid  out  1  one-cycle pulse; no backpressure.
- resp_paddr  out  PPN_W+OFF_W  {ppn, offset}.
- resp_hit  out  1  1 = TLB hit, 0 = filled from the page table.
- pt_lookup_rqst  out  1  drives LOOKUP_RQST; one-cycle pulse.
- pt_lookup_addr  out  VPN_W  drives LOOKUP_ADDR; held stable from the pulse until complete.
- pt_lookup_complete  in  1  from LOOKUP_COMPLETE; level, sampled on clk.
- pt_lookup_return  in  PPN_W  from LOOKUP_RETURN; valid while complete is high.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset: state IDLE; all entry valid bits 0; replacement pointer 0; req_ready 1; resp_valid, resp_hit, pt_lookup_rqst 0; resp_paddr, pt_lookup_addr, both counters 0.
- States:
  - IDLE: on accept, register addr and do a parallel compare of VPN against valid entries, then go to RESP (hit) or MREQ (miss).
  - MREQ: pt_lookup_rqst = 1 for exactly one cycle; pt_lookup_addr = VPN; go to MWAIT.
  - MWAIT: hold pt_lookup_addr; on the first sampled pt_lookup_complete = 1, capture pt_lookup_return, fill an entry, go to RESP.
  - RESP: resp_valid = 1 for one cycle, then IDLE.
- Latency: hit, resp_valid is asserted the cycle after acceptance. Miss, pt_lookup_rqst is asserted the cycle after acceptance, and resp_valid the cycle after complete is sampled.
- hit_count increments in the acceptance cycle on a hit; miss_count increments on a miss. Both saturate at all-ones; no wrap.
- Fill victim: lowest-index invalid entry. If all entries are valid, use the replacement pointer, then increment it modulo NUM_ENTRIES (wraps NUM_ENTRIES-1 -> 0). The pointer does not move on a fill into an invalid entry.
- Multiple matching entries cannot occur because fills happen only on a miss. The compare must nonetheless use the lowest-index match.
- flush: clears all valid bits in the cycle sampled, in any state; the replacement pointer resets to 0.
  - flush while a request is in flight: the in-flight translation still completes and resp_valid is still delivered.
  - flush in the same cycle as the fill: flush wins and the fill is dropped.
  - flush in the same cycle as a request is accepted in IDLE: the compare sees the pre-flush entries.
- pt_lookup_complete outside MWAIT is ignored.
- No timeout in MWAIT; the page table always completes.
- Reset mid-operation (any state): immediate return to reset values; no resp_valid is produced for the abandoned request, and a later pt_lookup_complete is ignored.
- PPN_W+OFF_W output width; concatenation only, no arithmetic on addresses.

Decomposition:
- tlb_pkg: default widths (VPN_W, OFF_W, PPN_W, CNT_W); state encoding IDLE/MREQ/MWAIT/RESP; entry struct {valid, vpn, ppn}.
- One sub-module, tlb_entry_array: holds the entries, the parallel match plus lowest-index hit encoder, victim selection, the replacement pointer, and flush.
- The FSM, counters and page-table handshake stay in tlb_front_end.

Test Plan:
1. After reset, req 0x0A3; PT raises complete with 0x7C three cycles after the rqst. Expect: one-cycle pt_lookup_rqst with pt_lookup_addr = 5; resp_paddr = 0xF83, resp_hit = 0; miss_count = 1.
2. Then req 0x0BF. Expect: resp_valid the next cycle, resp_paddr = 0xF9F, resp_hit = 1; no pt_lookup_rqst; hit_count = 1.
3. From reset, miss-fill VPNs 1, 2, 3, 4, then VPN 6 (fills entry 0, pointer -> 1), then req VPN 1. Expect: the VPN 1 request misses and fills entry 1; VPN 2 then misses; VPN 3 and 4 hit.
4. Assert flush in the same cycle that complete is sampled for VPN 7 (return 0x11). Expect: resp_paddr = {0x11, off}, resp_hit = 0; the next VPN 7 request misses.
5. Assert rst during MWAIT; raise complete 2 cycles after release. Expect: no resp_valid, req_ready = 1, both counters 0.
6. Hold req_valid during MWAIT with a different address. Expect: not accepted (req_ready = 0); it is accepted only in the IDLE cycle after RESP.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB front end.
// Contents:
//   - default widths for the virtual page number, page offset, physical page
//     number and statistics counters
//   - FSM state encoding (IDLE / MREQ / MWAIT / RESP)
//   - tlb_entry_t: one translation entry {valid, vpn, ppn} at default widths
package tlb_pkg;

  localparam int TLB_NUM_ENTRIES = 4;
  localparam int TLB_VPN_W       = 4;
  localparam int TLB_OFF_W       = 5;
  localparam int TLB_PPN_W       = 8;
  localparam int TLB_CNT_W       = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MREQ  = 2'd1;
  localparam logic [1:0] ST_MWAIT = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [TLB_VPN_W-1:0] vpn;
    logic [TLB_PPN_W-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_front_end_if.sv
// Bus bundle between a translation client / page table and tlb_front_end.
// Signals:
//   req_valid, req_addr, req_ready        translation request handshake
//   flush                                 invalidate all TLB entries
//   resp_valid, resp_paddr, resp_hit      one-cycle translation response
//   pt_lookup_rqst, pt_lookup_addr        lookup issued to the page table
//   pt_lookup_complete, pt_lookup_return  page-table answer
//   hit_count, miss_count                 saturating statistics
// Modports: slave = the TLB, master = everything that talks to it.
interface tlb_front_end_if
  import tlb_pkg::*;
#(
  parameter int VPN_W = TLB_VPN_W,
  parameter int OFF_W = TLB_OFF_W,
  parameter int PPN_W = TLB_PPN_W,
  parameter int CNT_W = TLB_CNT_W
) ();

  logic                   req_valid;
  logic [VPN_W+OFF_W-1:0] req_addr;
  logic                   req_ready;
  logic                   flush;
  logic                   resp_valid;
  logic [PPN_W+OFF_W-1:0] resp_paddr;
  logic                   resp_hit;
  logic                   pt_lookup_rqst;
  logic [VPN_W-1:0]       pt_lookup_addr;
  logic                   pt_lookup_complete;
  logic [PPN_W-1:0]       pt_lookup_return;
  logic [CNT_W-1:0]       hit_count;
  logic [CNT_W-1:0]       miss_count;

  modport slave (
    input  req_valid, req_addr, flush, pt_lookup_complete, pt_lookup_return,
    output req_ready, resp_valid, resp_paddr, resp_hit,
           pt_lookup_rqst, pt_lookup_addr, hit_count, miss_count
  );

  modport master (
    output req_valid, req_addr, flush, pt_lookup_complete, pt_lookup_return,
    input  req_ready, resp_valid, resp_paddr, resp_hit,
           pt_lookup_rqst, pt_lookup_addr, hit_count, miss_count
  );

endinterface

// File: rtl/tlb_entry_array.sv
// Fully-associative entry store for tlb_front_end.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   flush                  clear every valid bit and the replacement pointer
//   lookup_vpn             VPN compared against all valid entries in parallel
//   lookup_hit/lookup_ppn  combinational result, lowest-index match wins
//   fill_en/fill_vpn/_ppn  write one entry (lowest invalid, else round robin)
module tlb_entry_array #(
  parameter int NUM_ENTRIES = 4,
  parameter int VPN_W       = 4,
  parameter int PPN_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             lookup_hit,
  output logic [PPN_W-1:0] lookup_ppn,
  input  logic             fill_en,
  input  logic [VPN_W-1:0] fill_vpn,
  input  logic [PPN_W-1:0] fill_ppn
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] valid_reg;
  logic [VPN_W-1:0]       vpn_reg [NUM_ENTRIES];
  logic [PPN_W-1:0]       ppn_reg [NUM_ENTRIES];
  logic [IDX_W-1:0]       repl_ptr_reg;

  logic [NUM_ENTRIES-1:0] match;
  logic [IDX_W-1:0]       victim_idx;
  logic                   all_valid;

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (vpn_reg[gi] == lookup_vpn);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_ppn = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        lookup_hit = 1'b1;
        lookup_ppn = ppn_reg[i];
      end
    end
  end

  // Lowest invalid entry if any; otherwise the round-robin pointer.
  always_comb begin
    all_valid  = &valid_reg;
    victim_idx = repl_ptr_reg;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) victim_idx = IDX_W'(i);
    end
  end

  // Flush has priority over a fill landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg    <= '0;
      repl_ptr_reg <= '0;
    end else if (flush) begin
      valid_reg    <= '0;
      repl_ptr_reg <= '0;
    end else if (fill_en) begin
      valid_reg[victim_idx] <= 1'b1;
      if (all_valid) repl_ptr_reg <= repl_ptr_reg + IDX_W'(1);
    end
  end

  // Tag/data storage needs no reset: nothing is visible until valid is set.
  always_ff @(posedge clk) begin
    if (fill_en && !flush) begin
      vpn_reg[victim_idx] <= fill_vpn;
      ppn_reg[victim_idx] <= fill_ppn;
    end
  end

endmodule

// File: rtl/tlb_front_end.sv
// TLB sitting in front of the page table. Hits answer the cycle after
// acceptance; misses issue one page-table lookup, fill an entry and answer
// the cycle after the page table completes.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  tlb_front_end_if.slave (request, response, page-table, counters)
module tlb_front_end
  import tlb_pkg::*;
#(
  parameter int NUM_ENTRIES = TLB_NUM_ENTRIES,
  parameter int VPN_W       = TLB_VPN_W,
  parameter int OFF_W       = TLB_OFF_W,
  parameter int PPN_W       = TLB_PPN_W,
  parameter int CNT_W       = TLB_CNT_W
) (
  input logic           clk,
  input logic           rst,
  tlb_front_end_if.slave bus
);

  logic [1:0]             state_reg, state_next;
  logic [OFF_W-1:0]       off_reg;
  logic [VPN_W-1:0]       lookup_addr_reg;
  logic [PPN_W+OFF_W-1:0] paddr_reg;
  logic                   hit_reg;
  logic [CNT_W-1:0]       hit_cnt_reg;
  logic [CNT_W-1:0]       miss_cnt_reg;

  logic [VPN_W-1:0] req_vpn;
  logic [OFF_W-1:0] req_off;
  logic             accept;
  logic             fill_en;
  logic             lookup_hit;
  logic [PPN_W-1:0] lookup_ppn;

  assign req_vpn = bus.req_addr[VPN_W+OFF_W-1:OFF_W];
  assign req_off = bus.req_addr[OFF_W-1:0];
  assign accept  = (state_reg == ST_IDLE) && bus.req_valid;
  // Completion is only meaningful while waiting; elsewhere it is ignored.
  assign fill_en = (state_reg == ST_MWAIT) && bus.pt_lookup_complete;

  tlb_entry_array #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .VPN_W       (VPN_W),
    .PPN_W       (PPN_W)
  ) u_entries (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .lookup_vpn (req_vpn),
    .lookup_hit (lookup_hit),
    .lookup_ppn (lookup_ppn),
    .fill_en    (fill_en),
    .fill_vpn   (lookup_addr_reg),
    .fill_ppn   (bus.pt_lookup_return)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = lookup_hit ? ST_RESP : ST_MREQ;
      ST_MREQ:  state_next = ST_MWAIT;
      ST_MWAIT: if (bus.pt_lookup_complete) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      off_reg         <= '0;
      lookup_addr_reg <= '0;
      paddr_reg       <= '0;
      hit_reg         <= 1'b0;
      hit_cnt_reg     <= '0;
      miss_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        off_reg <= req_off;
        hit_reg <= lookup_hit;
        if (lookup_hit) begin
          paddr_reg <= {lookup_ppn, req_off};
          if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
        end else begin
          lookup_addr_reg <= req_vpn;
          if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
        end
      end
      // The response is formed from the returned PPN even if a flush drops
      // the fill in this same cycle.
      if (fill_en) paddr_reg <= {bus.pt_lookup_return, off_reg};
    end
  end

  assign bus.req_ready      = (state_reg == ST_IDLE);
  assign bus.resp_valid     = (state_reg == ST_RESP);
  assign bus.resp_paddr     = paddr_reg;
  assign bus.resp_hit       = hit_reg;
  assign bus.pt_lookup_rqst = (state_reg == ST_MREQ);
  assign bus.pt_lookup_addr = lookup_addr_reg;
  assign bus.hit_count      = hit_cnt_reg;
  assign bus.miss_count     = miss_cnt_reg;

endmodule

// File: tb/tb_tlb_front_end.sv
// Self-checking bench for tlb_front_end: directed scenarios followed by
// randomized traffic. A driver issues requests and plays the page table;
// the expected response of each request is queued, and a separate monitor
// pops and compares whenever resp_valid is seen.
module tb_tlb_front_end;
  import tlb_pkg::*;

  localparam int N    = 4;
  localparam int VW   = 4;
  localparam int OW   = 5;
  localparam int PW   = 8;
  localparam int CW   = 3;              // narrow counters so saturation is reached
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_front_end_if #(.VPN_W(VW), .OFF_W(OW), .PPN_W(PW), .CNT_W(CW)) bus ();

  tlb_front_end #(
    .NUM_ENTRIES (N),
    .VPN_W       (VW),
    .OFF_W       (OW),
    .PPN_W       (PW),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int resp_seen = 0;

  typedef struct {
    logic [PW+OW-1:0] paddr;
    bit               hit;
  } exp_t;
  exp_t sb[$];

  // Reference model: translation contents, round-robin pointer, statistics.
  tlb_entry_t    m_ent [N];
  int            m_ptr;
  int            m_hits;
  int            m_miss;
  logic [PW-1:0] pt_mem [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_ent[i] = '0;
    m_ptr  = 0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < N; i++) m_ent[i].valid = 1'b0;
    m_ptr = 0;
  endtask

  task automatic model_fill(input logic [VW-1:0] v, input logic [PW-1:0] p);
    int vic;
    vic = -1;
    for (int i = 0; i < N; i++) if (vic < 0 && !m_ent[i].valid) vic = i;
    if (vic < 0) begin
      vic   = m_ptr;
      m_ptr = (m_ptr + 1) % N;
    end
    m_ent[vic].valid = 1'b1;
    m_ent[vic].vpn   = v;
    m_ent[vic].ppn   = p;
  endtask

  task automatic model_issue(input logic [VW+OW-1:0] a, output bit hit);
    logic [VW-1:0] v;
    logic [OW-1:0] o;
    logic [PW-1:0] p;
    exp_t e;
    v   = a[VW+OW-1:OW];
    o   = a[OW-1:0];
    hit = 1'b0;
    p   = pt_mem[v];
    for (int i = 0; i < N; i++) begin
      if (!hit && m_ent[i].valid && m_ent[i].vpn == v) begin
        hit = 1'b1;
        p   = m_ent[i].ppn;
      end
    end
    e.paddr = {p, o};
    e.hit   = hit;
    sb.push_back(e);
    if (hit) begin
      if (m_hits < CMAX) m_hits++;
    end else begin
      if (m_miss < CMAX) m_miss++;
    end
  endtask

  // Monitor: compare every response against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      exp_t e;
      resp_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_resp actual=resp_valid required=no_response t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("resp_paddr", 32'(bus.resp_paddr), 32'(e.paddr));
        chk("resp_hit", 32'(bus.resp_hit), 32'(e.hit));
      end
    end
  end

  task automatic chk_reset_state();
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_hit", 32'(bus.resp_hit), 0);
    chk("rst_rqst", 32'(bus.pt_lookup_rqst), 0);
    chk("rst_paddr", 32'(bus.resp_paddr), 0);
    chk("rst_lookup_addr", 32'(bus.pt_lookup_addr), 0);
    chk("rst_hit_count", 32'(bus.hit_count), 0);
    chk("rst_miss_count", 32'(bus.miss_count), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    bus.pt_lookup_complete = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_reset();
    chk_reset_state();
  endtask

  // One translation, entered and left at a negedge with the DUT in IDLE.
  // fl_acc: flush in the acceptance cycle; fl_mid: flush in the first wait
  // cycle; fl_fill: flush in the completion cycle; hold: present b while busy.
  task automatic xact(input logic [VW+OW-1:0] a, input int dly, input bit fl_acc,
                      input bit fl_mid, input bit fl_fill, input bit hold,
                      input logic [VW+OW-1:0] b);
    bit hit;
    logic [VW-1:0] v;
    v = a[VW+OW-1:OW];
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.flush     = fl_acc;
    model_issue(a, hit);
    if (fl_acc) model_flush();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("lookup_rqst", 32'(bus.pt_lookup_rqst), hit ? 0 : 1);
    if (hit) begin
      chk("hit_latency", 32'(bus.resp_valid), 1);
    end else begin
      chk("lookup_addr", 32'(bus.pt_lookup_addr), 32'(v));
      @(negedge clk);
      chk("rqst_pulse", 32'(bus.pt_lookup_rqst), 0);
      if (hold) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = b;
      end
      for (int i = 0; i < dly; i++) begin
        bus.flush = fl_mid && (i == 0);
        if (bus.flush) model_flush();
        chk("ready_busy", 32'(bus.req_ready), 0);
        @(negedge clk);
      end
      chk("addr_hold", 32'(bus.pt_lookup_addr), 32'(v));
      bus.flush              = fl_fill;
      bus.pt_lookup_complete = 1'b1;
      bus.pt_lookup_return   = pt_mem[v];
      if (fl_fill) model_flush();
      else model_fill(v, pt_mem[v]);
      @(negedge clk);
      bus.pt_lookup_complete = 1'b0;
      bus.flush              = 1'b0;
      bus.pt_lookup_return   = PW'($urandom);
      chk("miss_latency", 32'(bus.resp_valid), 1);
      if (hold) chk("ready_in_resp", 32'(bus.req_ready), 0);
    end
    chk("hit_count", 32'(bus.hit_count), 32'(m_hits));
    chk("miss_count", 32'(bus.miss_count), 32'(m_miss));
    @(negedge clk);
    chk("resp_pulse", 32'(bus.resp_valid), 0);
  endtask

  function automatic logic [VW+OW-1:0] mk(input int vpn, input int off);
    return {VW'(vpn), OW'(off)};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [VW+OW-1:0] a, b, pend;
    bit have_pend, hold;

    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.flush = 1'b0;
    bus.pt_lookup_complete = 1'b0;
    bus.pt_lookup_return = '0;
    for (int i = 0; i < 16; i++) pt_mem[i] = PW'($urandom);
    pt_mem[5] = 8'h7C;
    pt_mem[7] = 8'h11;
    model_reset();

    do_reset();

    // Miss then hit on VPN 5.
    xact(9'h0A3, 2, 0, 0, 0, 0, '0);
    xact(9'h0BF, 1, 0, 0, 0, 0, '0);

    // Replacement order from an empty TLB.
    do_reset();
    xact(mk(1, 3), 1, 0, 0, 0, 0, '0);
    xact(mk(2, 4), 2, 0, 0, 0, 0, '0);
    xact(mk(3, 5), 1, 0, 0, 0, 0, '0);
    xact(mk(4, 6), 3, 0, 0, 0, 0, '0);
    xact(mk(6, 7), 1, 0, 0, 0, 0, '0);
    xact(mk(1, 8), 1, 0, 0, 0, 0, '0);
    xact(mk(3, 9), 1, 0, 0, 0, 0, '0);
    xact(mk(4, 10), 1, 0, 0, 0, 0, '0);
    xact(mk(2, 11), 1, 0, 0, 0, 0, '0);

    // Flush coincident with the fill of VPN 7: response delivered, fill dropped.
    xact(mk(7, 2), 2, 0, 0, 1, 0, '0);
    xact(mk(7, 9), 1, 0, 0, 0, 0, '0);

    // A request held during MWAIT is only taken after RESP.
    xact(mk(9, 1), 3, 0, 0, 0, 1, mk(7, 20));
    xact(mk(7, 20), 1, 0, 0, 0, 0, '0);

    // Reset while waiting on the page table; a late completion is ignored.
    bus.req_valid = 1'b1;
    bus.req_addr  = mk(15, 5);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_test_rqst", 32'(bus.pt_lookup_rqst), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_reset();
    chk_reset_state();
    seen = resp_seen;
    @(negedge clk);
    @(negedge clk);
    bus.pt_lookup_complete = 1'b1;
    bus.pt_lookup_return   = 8'h5A;
    @(negedge clk);
    bus.pt_lookup_complete = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_resp_after_rst", 32'(resp_seen), 32'(seen));
    chk_reset_state();

    // Randomized traffic over a small VPN set so hits, evictions and counter
    // saturation all occur.
    have_pend = 1'b0;
    pend = '0;
    for (int k = 0; k < 90; k++) begin
      if (have_pend) a = pend;
      else a = {VW'($urandom_range(0, 7)), OW'($urandom_range(0, 31))};
      hold = ($urandom_range(0, 5) == 0);
      b = {VW'($urandom_range(0, 7)), OW'($urandom_range(0, 31))};
      if ($urandom_range(0, 9) == 0) pt_mem[$urandom_range(0, 15)] = PW'($urandom);
      xact(a, $urandom_range(1, 4), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), hold, b);
      have_pend = hold && bus.req_valid;
      pend = b;
      if (!have_pend) bus.req_valid = 1'b0;
      if (!have_pend && $urandom_range(0, 4) == 0) begin
        // Completion while idle must not produce anything.
        bus.pt_lookup_complete = 1'b1;
        bus.pt_lookup_return   = PW'($urandom);
        @(negedge clk);
        bus.pt_lookup_complete = 1'b0;
        chk("idle_complete_ignored", 32'(bus.req_ready), 1);
      end
    end
    if (have_pend) xact(pend, 1, 0, 0, 0, 0, '0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
